bcd_tick_counter: RTL
=====================

BCD_TICK_COUNTER -- requirements
Module: bcd_tick_counter

Interface
REQ-001 Parameter: TICK_DIV, default 50000000, number of CLOCK_50 cycles per count step (legal range 2..2^26).
REQ-002 Port: CLOCK_50  input  1  single system clock; all state changes on its rising edge.
REQ-003 Port: KEY0  input  1  reset; asynchronous, active-low.
REQ-004 Port: en  input  1  count enable; high = prescaler runs and count steps on each tick.
REQ-005 Port: up  input  1  direction; 1 = increment, 0 = decrement.
REQ-006 Port: load  input  1  synchronous load request, level-sampled each cycle.
REQ-007 Port: load_val  input  8  BCD load value; [7:4] tens, [3:0] units.
REQ-008 Port: bcd  output  8  registered count; [7:4] tens, [3:0] units; drives the two-digit 7-segment decoders.
REQ-009 Port: tc  output  1  terminal-count pulse, one cycle wide.
REQ-010 Port: load_err  output  1  sticky flag; last load request was rejected.

Function
REQ-011 bcd SHALL always hold a valid two-digit BCD value (each nibble 0..9).
REQ-012 Prescaler SHALL be a counter 0..TICK_DIV-1. It SHALL advance only while en=1 and load=0, and SHALL clear to 0 whenever en=0 or load=1.
REQ-013 Tick SHALL assert for exactly one cycle when the prescaler equals TICK_DIV-1 and en=1. The prescaler SHALL wrap to 0 on that cycle.
REQ-014 On tick with up=1: units 0..8 increment. Units 9 -> 0, with a carry into tens. Tens 9 with a carry -> 0.
REQ-015 On tick with up=0: units 1..9 decrement. Units 0 -> 9, with a borrow from tens. Tens 0 with a borrow -> 9.
REQ-016 tc SHALL pulse high in the cycle after a tick that wraps the count, i.e. 99->00 when up=1 or 00->99 when up=0. It SHALL be low at all other times.
REQ-017 Load acceptance: load=1 and both load_val nibbles <=9 -> bcd <= load_val next cycle, load_err <= 0, and no tick or tc is generated in that cycle.
REQ-018 Load rejection: load=1 and either nibble >9 -> bcd is unchanged, load_err <= 1, and the prescaler still clears.
REQ-019 load_err SHALL remain 1 until an accepted load or a reset. Counting SHALL NOT clear it.
REQ-020 Priority, highest first: reset, load, tick. A load coinciding with a would-be tick SHALL suppress the step and tc.
REQ-021 A direction change takes effect on the next tick. up is sampled in the tick cycle only.
REQ-022 Count step latency: bcd updates on the clock edge that ends the tick cycle.
REQ-023 With en=0 and load=0, bcd, tc=0 and load_err SHALL hold indefinitely.

Reset
REQ-024 KEY0=0 SHALL immediately force bcd=8'h00, tc=0, load_err=0 and prescaler=0, without waiting for a clock edge.
REQ-025 Reset asserted mid-count or mid-tick SHALL discard any pending step or tc.
REQ-026 Reset release SHALL be synchronised so that state exits reset only on a CLOCK_50 edge. The first tick after release SHALL occur TICK_DIV cycles after the first enabled cycle.

Verification (TICK_DIV=4)
REQ-027 Reset, then en=1, up=1 for 40 cycles -> bcd steps 00,01,...,09,10 every 4 cycles; tc stays 0.
REQ-028 Load 8'h98, en=1, up=1 -> bcd 99, then 00 with a single-cycle tc on the 00 transition, then 01.
REQ-029 Load 8'h01, up=0 -> bcd 00, then 99 with tc=1 for one cycle, then 98.
REQ-030 load_val=8'h3A with load=1 while bcd=8'h42 -> bcd stays 42, load_err=1. Counting continues, load_err stays 1. A later load of 8'h15 -> bcd=15, load_err=0.
REQ-031 Assert load on the exact cycle the prescaler=3 -> bcd=load_val, no step, no tc. The next step occurs 4 enabled cycles later.
REQ-032 Drop KEY0 asynchronously between clock edges while bcd=8'h57 and load_err=1 -> bcd=00, load_err=0 and tc=0 before the next edge. Resume after release per REQ-026.

Source files
------------

// File: rtl/bcd_tick_counter.sv
// Two-digit BCD up/down counter stepped by a prescaled tick, with synchronous
// load (validated), sticky load-error flag and a one-cycle terminal-count pulse.
module bcd_tick_counter #(
  parameter int TICK_DIV = 50000000
) (
  input  logic       CLOCK_50,
  input  logic       KEY0,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] bcd,
  output logic       tc,
  output logic       load_err
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic [1:0]    rst_sync;
  logic          rst_n;
  logic [PW-1:0] presc;
  logic          tick;
  logic          load_ok;
  logic [7:0]    bcd_nxt;
  logic          wrap;
  logic [3:0]    units;
  logic [3:0]    tens;

  // NOTE: reset asserts asynchronously but releases only after two clean edges,
  // so no flop can see reset removal close to its clock edge.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) rst_sync <= 2'b00;
    else       rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n   = rst_sync[1];
  assign units   = bcd[3:0];
  assign tens    = bcd[7:4];
  assign load_ok = (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9);
  assign tick    = en && !load && (presc == PRESC_MAX);

  // Next BCD value for one step in the current direction; wrap marks 99->00 / 00->99.
  always_comb begin
    bcd_nxt = bcd;
    wrap    = 1'b0;
    if (up) begin
      if (units == 4'd9) begin
        bcd_nxt[3:0] = 4'd0;
        if (tens == 4'd9) begin
          bcd_nxt[7:4] = 4'd0;
          wrap         = 1'b1;
        end else begin
          bcd_nxt[7:4] = tens + 4'd1;
        end
      end else begin
        bcd_nxt[3:0] = units + 4'd1;
      end
    end else begin
      if (units == 4'd0) begin
        bcd_nxt[3:0] = 4'd9;
        if (tens == 4'd0) begin
          bcd_nxt[7:4] = 4'd9;
          wrap         = 1'b1;
        end else begin
          bcd_nxt[7:4] = tens - 4'd1;
        end
      end else begin
        bcd_nxt[3:0] = units - 4'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      presc    <= '0;
      bcd      <= 8'h00;
      tc       <= 1'b0;
      load_err <= 1'b0;
    end else begin
      if (!en || load || presc == PRESC_MAX) presc <= '0;
      else                                   presc <= presc + 1'b1;

      tc <= 1'b0;
      if (load) begin
        if (load_ok) begin
          bcd      <= load_val;
          load_err <= 1'b0;
        end else begin
          load_err <= 1'b1;
        end
      end else if (tick) begin
        bcd <= bcd_nxt;
        tc  <= wrap;
      end
    end
  end

endmodule
